// File: rtl/sum_accumulator.sv
// Block accumulator behind the ripple-carry adder: sums M {carry,sum} samples and
// hands the total downstream over valid/ready. Optional macro SUM_ACC_SAT_EN selects saturation.
module sum_accumulator #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned ACC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [N:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_ovf,
  output logic [$clog2(M+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(M+1);
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;
  logic [SUM_W-1:0]   w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_add;

  // Handshake decodes come straight from the state register.
  assign w_in_ready  = (r_state == S_IDLE) || (r_state == S_ACC);
  assign w_out_valid = (r_state == S_DONE);
  assign w_accept    = in_valid && w_in_ready;
  assign w_last      = (r_count == CNT_W'(M - 1));

  // One extra bit catches the carry-out of the accumulate.
  assign w_sum   = {1'b0, r_acc} + SUM_W'(in_data);
  assign w_carry = w_sum[ACC_W];

`ifdef SUM_ACC_SAT_EN
  assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // clear outranks both handshakes and also completes a pending output.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            w_acc_nxt   = w_acc_add;
            w_count_nxt = r_count + CNT_W'(1);
            w_ovf_nxt   = r_ovf | w_carry;
            w_state_nxt = w_last ? S_DONE : S_ACC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  assign count     = r_count;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance plus a 6-bit accumulator
// instance for the overflow case (expectation follows SUM_ACC_SAT_EN).
module tb_sum_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic [2:0] count;

  logic       v2;
  logic [4:0] d2;
  logic       clr2;
  logic       ir2;
  logic       ov2;
  logic       or2;
  logic [5:0] sum2;
  logic       ovf2;
  logic [2:0] cnt2;

  int n_checks;
  int n_fail;

`ifdef SUM_ACC_SAT_EN
  localparam int unsigned OVF_SUM = 63;
`else
  localparam int unsigned OVF_SUM = 60;
`endif

  sum_accumulator #(.N(4), .M(4), .ACC_W(8)) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .count(count)
  );

  sum_accumulator #(.N(4), .M(4), .ACC_W(6)) u_ovf (
    .clk(clk), .rst(rst), .clear(clr2),
    .in_valid(v2), .in_data(d2), .in_ready(ir2),
    .out_valid(ov2), .out_ready(or2),
    .out_sum(sum2), .out_ovf(ovf2), .count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 5'd0;
  endtask

  task automatic idle_state(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_sum"},       32'(out_sum),   32'd0);
    check({tag, "_ovf"},       32'(out_ovf),   32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 5'd0;
    out_ready = 1'b0;
    v2        = 1'b0;
    d2        = 5'd0;
    clr2      = 1'b0;
    or2       = 1'b0;

    #12;
    idle_state("reset");
    rst = 1'b0;
    tick();

    // Basic block
    out_ready = 1'b1;
    send(5'd5);
    check("basic_cnt1", 32'(count), 32'd1);
    send(5'd10);
    send(5'd31);
    send(5'd1);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_sum",   32'(out_sum),   32'd47);
    check("basic_ovf",   32'(out_ovf),   32'd0);
    check("basic_rdy",   32'(in_ready),  32'd0);
    check("basic_cnt4",  32'(count),     32'd4);
    tick();
    idle_state("basic_after");

    // Overflow on the 6-bit instance
    v2 = 1'b1;
    d2 = 5'd31;
    repeat (4) tick();
    v2 = 1'b0;
    check("ovf_valid", 32'(ov2),  32'd1);
    check("ovf_sum",   32'(sum2), OVF_SUM);
    check("ovf_flag",  32'(ovf2), 32'd1);
    or2 = 1'b1;
    tick();
    check("ovf_release", 32'(ov2),  32'd0);
    check("ovf_cleared", 32'(ovf2), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    send(5'd1);
    send(5'd2);
    send(5'd3);
    send(5'd4);
    in_valid = 1'b1;
    in_data  = 5'd9;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum",       32'(out_sum),   32'd10);
      check("bp_count",     32'(count),     32'd4);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    idle_state("bp_after");

    // Bubbles: odd cycles carry junk data with in_valid low
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? 5'd7 : 5'd30;
      tick();
      check("bubble_count", 32'(count), 32'(i / 2 + 1));
    end
    in_valid = 1'b0;
    check("bubble_sum",   32'(out_sum),   32'd28);
    check("bubble_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();

    // Clear mid-block drops the coincident sample
    send(5'd9);
    send(5'd9);
    check("clr_pre_cnt", 32'(count),   32'd2);
    check("clr_pre_sum", 32'(out_sum), 32'd18);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd9;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    idle_state("clr_after");
    repeat (4) send(5'd1);
    check("clr_next_sum", 32'(out_sum), 32'd4);
    tick();

    // Clear from DONE with output stalled
    out_ready = 1'b0;
    repeat (4) send(5'd3);
    check("clr_done_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle_state("clr_done");

    // Async reset between edges
    send(5'd2);
    send(5'd3);
    send(5'd4);
    check("rst_pre_cnt", 32'(count),   32'd3);
    check("rst_pre_sum", 32'(out_sum), 32'd9);
    #3 rst = 1'b1;
    #1;
    idle_state("async_rst");
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    repeat (4) send(5'd2);
    check("rst_next_valid", 32'(out_valid), 32'd1);
    check("rst_next_sum",   32'(out_sum),   32'd8);
    tick();
    idle_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

- Downstream stage of the N-bit ripple-carry adder.
- Consumes the adder's (N+1)-bit unsigned result `{carry, sum}`, one sample per valid/ready handshake.
- Accumulates M consecutive samples into an ACC_W-bit register and presents the block total on a second valid/ready output port, with a sticky overflow flag.
- Converts the adder's combinational output into a registered, flow-controlled block sum for downstream logic.

## Interface
- `N`, default 4: adder width; input sample is N+1 bits.
- `M`, default 4: samples per block; legal range ≥ 1.
- `ACC_W`, default 8: accumulator width; legal range ACC_W ≥ N+1.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `clear` input, 1 bit: synchronous abort of the current block.
- `in_valid` input, 1 bit: `in_data` is valid this cycle.
- `in_data` input, N+1 bits: unsigned adder result `{carry, sum}`.
- `in_ready` output, 1 bit: block can accept a sample this cycle.
- `out_valid` output, 1 bit: block total is available.
- `out_ready` input, 1 bit: consumer accepts the total this cycle.
- `out_sum` output, ACC_W bits: accumulated total of the block.
- `out_ovf` output, 1 bit: sticky flag, set when any addition in the block exceeded 2^ACC_W−1.
- `count` output, $clog2(M+1) bits: number of samples accepted in the current block.

## Operation
- FSM has three states:
  - IDLE: count = 0, acc = 0.
  - ACC: 0 < count < M.
  - DONE: count = M, total held.
- `in_ready` = 1 in IDLE and ACC; 0 in DONE. `out_valid` = 1 only in DONE.
- Accept condition: `in_valid && in_ready`. On accept:
  - acc ← acc + zero-extended `in_data`.
  - count ← count + 1.
  - `ovf` ← `ovf` | carry-out of that addition.
- State transitions:
  - IDLE → ACC on accept when M > 1.
  - IDLE → DONE on accept when M = 1.
  - ACC → DONE on the accept that makes count = M.
  - ACC and IDLE are otherwise held when `in_valid` = 0.
- DONE:
  - `out_sum` and `out_ovf` are held stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`: go to IDLE; clear acc, count and ovf.
- `out_sum` is driven from the acc register in all states. It is meaningful only while `out_valid` = 1.
- Default arithmetic is modulo 2^ACC_W: wraps on overflow and sets `ovf`. See Configuration for the saturating variant.
- `clear`:
  - Priority is above every handshake.
  - Next state is IDLE with acc, count and ovf = 0, including from DONE.
  - A sample presented in the same cycle as `clear` is dropped.
  - An output handshake in the same cycle as `clear` is treated as completed.
- Reset values: state = IDLE, acc = 0, count = 0, ovf = 0. Therefore `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `count` = 0.

## Timing
- Everything registered on the `clk` rising edge except:
  - `in_ready`, a combinational decode of state.
  - `out_valid`, a combinational decode of state.
- Latency: `out_valid` rises on the cycle after the M-th accepting edge.
- Throughput: M samples per M+1 cycles minimum, because `in_ready` = 0 for at least one DONE cycle.
- `rst` assertion mid-block or mid-DONE clears all state immediately, without waiting for a clock edge. Operation resumes on the first edge after deassertion.
- `in_data` is sampled only on accepting edges. Its value in any other cycle has no effect.

## Configuration
- Macro: `SUM_ACC_SAT_EN`.
- Defined:
  - acc saturates at 2^ACC_W−1 instead of wrapping.
  - `ovf` is still set on the first saturating add.
  - Further accepts leave acc at its maximum.
- Undefined: modulo-2^ACC_W wrap. No saturation logic is synthesised.

## Test plan
All scenarios use N = 4, M = 4, ACC_W = 8 unless stated.
- Basic block: samples 5, 10, 31, 1 on consecutive cycles, `out_ready` = 1 → `out_valid` one cycle after the 4th accept, `out_sum` = 47, `out_ovf` = 0, then IDLE with `count` = 0.
- Overflow, ACC_W = 6: samples 31, 31, 31, 31 →
  - Without `SUM_ACC_SAT_EN`: `out_sum` = 60, `out_ovf` = 1.
  - With `SUM_ACC_SAT_EN`: `out_sum` = 63, `out_ovf` = 1.
- Backpressure: complete a block of 1, 2, 3, 4, then hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 → `in_ready` = 0 throughout, `out_sum` = 10 stable, no sample absorbed. Raise `out_ready` → IDLE next cycle.
- Bubbles: 4 samples of 7 with `in_valid` toggling 1/0 → `count` increments only on accepting edges, `out_sum` = 28.
- Clear: accept 9 and 9, assert `clear` together with `in_valid` and `in_data` = 9 → `count` = 0, acc = 0. Next block 1, 1, 1, 1 yields `out_sum` = 4.
- Async reset: assert `rst` between edges after 3 accepts → outputs go to reset values before the next edge. After deassertion, a full block of 2, 2, 2, 2 yields `out_sum` = 8.
